// File: rtl/memory_stage.sv
// memory_stage: RV32I M stage with multi-cycle word data memory, M/W register and writeback mux.
module memory_stage #(
  parameter int WORD_SIZE   = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] ALUResultM,
  input  logic [WORD_SIZE-1:0] WriteDataM,
  input  logic [WORD_SIZE-1:0] PCPlus4M,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  output logic                 StallM,
  output logic [WORD_SIZE-1:0] ALUResultW,
  output logic [WORD_SIZE-1:0] ReadDataW,
  output logic [WORD_SIZE-1:0] PCPlus4W,
  output logic [4:0]           RdW,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [WORD_SIZE-1:0] ResultW
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [WORD_SIZE-1:0] alu;
    logic [WORD_SIZE-1:0] rdata;
    logic [WORD_SIZE-1:0] pc4;
    logic [4:0]           rd;
    logic                 regw;
    logic [1:0]           rsrc;
  } w_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  w_t w_q, w_d;
  logic mem_op, in_range, complete, stall;
  logic [WORD_SIZE-1:0] widx, rdata;
  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];
  assign mem_op   = MemWriteM | (ResultSrcM == 2'b01);
  assign widx     = ALUResultM >> 2;
  assign in_range = widx < WORD_SIZE'(MEM_DEPTH);
  assign rdata    = in_range ? mem[widx[AW-1:0]] : '0;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    if (state_q == BUSY) begin
      cnt_d    = cnt_q - CW'(1);
      stall    = cnt_q > CW'(1);
      complete = cnt_q == CW'(1);
      state_d  = complete ? IDLE : BUSY;
    end else if (mem_op && MEM_LATENCY > 1) begin
      stall   = 1'b1;
      cnt_d   = CW'(MEM_LATENCY - 1);
      state_d = BUSY;
    end else begin
      complete = 1'b1;
    end
  end
  // Anything short of the completion cycle pushes a bubble into W.
  always_comb begin
    w_d = '0;
    if (complete) begin
      w_d.alu   = ALUResultM;
      w_d.rdata = (ResultSrcM == 2'b01) ? rdata : '0;
      w_d.pc4   = PCPlus4M;
      w_d.rd    = RdM;
      w_d.regw  = RegWriteM;
      w_d.rsrc  = ResultSrcM;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end
  always_ff @(posedge clk) begin
    if (complete && MemWriteM && in_range) mem[widx[AW-1:0]] <= WriteDataM;
  end
  assign StallM     = stall & ~rst;
  assign ALUResultW = w_q.alu;
  assign ReadDataW  = w_q.rdata;
  assign PCPlus4W   = w_q.pc4;
  assign RdW        = w_q.rd;
  assign RegWriteW  = w_q.regw;
  assign ResultSrcW = w_q.rsrc;
  assign ResultW    = w_q.rsrc == 2'b00 ? w_q.alu :
                      w_q.rsrc == 2'b01 ? w_q.rdata :
                      w_q.rsrc == 2'b10 ? w_q.pc4 : '0;
endmodule
